// File: rtl/divider_fixed_point_16_bit_pkg.sv
// Shared state encoding, default widths and saturation constants for the fixed-point divider.
package divider_fixed_point_16_bit_pkg;

    localparam int DefaultQ = 12;
    localparam int DefaultN = 16;

    localparam logic [1:0] StIdleEnc   = 2'd0;
    localparam logic [1:0] StCalcEnc   = 2'd1;
    localparam logic [1:0] StFinishEnc = 2'd2;
    localparam logic [1:0] StDoneEnc   = 2'd3;

    typedef enum logic [1:0] {
        StIdle   = StIdleEnc,
        StCalc   = StCalcEnc,
        StFinish = StFinishEnc,
        StDone   = StDoneEnc
    } state_e;

    localparam logic [DefaultN-1:0] SatNeg = {1'b1, {(DefaultN-1){1'b0}}};
    localparam logic [DefaultN-1:0] SatPos = ~SatNeg;

endpackage

// File: rtl/divider_restoring_core.sv
// Unsigned restoring divider: one quotient bit per step, MSB first. Knows nothing of sign.
module divider_restoring_core #(
    parameter int W  = 16,  // divisor and remainder width
    parameter int QW = 28   // dividend/quotient width, equal to the number of steps
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  logic [QW-1:0] dividend,
    input  logic [W-1:0]  divisor,
    output logic [QW-1:0] quotient,
    output logic          last
);

    localparam int CntW = $clog2(QW + 1);

    logic [W-1:0]    rem_q;
    logic [QW-1:0]   shift_q;  // dividend bits leave at the top, quotient bits enter at the bottom
    logic [W-1:0]    div_q;
    logic [CntW-1:0] cnt_q;

    logic [W:0] trial;
    logic [W:0] diff;
    logic       fits;

    // The trial value is the (W+1)-bit partial remainder; a borrow out of the subtraction
    // means the divisor does not fit and the remainder is restored.
    always_comb begin
        trial = {rem_q, shift_q[QW-1]};
        diff  = trial - {1'b0, div_q};
        fits  = ~diff[W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q   <= '0;
            shift_q <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
        end else if (load) begin
            rem_q   <= '0;
            shift_q <= dividend;
            div_q   <= divisor;
            cnt_q   <= CntW'(QW);
        end else if (step && (cnt_q != '0)) begin
            rem_q   <= fits ? diff[W-1:0] : trial[W-1:0];
            shift_q <= {shift_q[QW-2:0], fits};
            cnt_q   <= cnt_q - 1'b1;
        end
    end

    assign quotient = shift_q;
    assign last     = (cnt_q == CntW'(1));

endmodule

// File: rtl/divider_fixed_point_16_bit.sv
// Signed Q(N-Q).Q fixed-point divider with saturation and divide-by-zero handling.
// Define DIV_ROUNDING_EN to add a guard bit and round the magnitude half-up.
module divider_fixed_point_16_bit
    import divider_fixed_point_16_bit_pkg::*;
#(
    parameter int Q = DefaultQ,
    parameter int N = DefaultN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] q_result,
    output logic         busy,
    output logic         done,
    output logic         overflow,
    output logic         div_by_zero
);

`ifdef DIV_ROUNDING_EN
    localparam int QW = N + Q + 1;
`else
    localparam int QW = N + Q;
`endif
    localparam int MagW = N + Q + 1;  // room for a rounding carry

    localparam logic [N-1:0] SatNegN = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] SatPosN = ~SatNegN;

    state_e state_q;
    logic   sign_q;
    logic   a_sign_q;
    logic   b_zero_q;

    logic [N-1:0]    abs_a;
    logic [N-1:0]    abs_b;
    logic [QW-1:0]   dividend;
    logic [QW-1:0]   quotient;
    logic            core_last;
    logic [MagW-1:0] mag;
    logic            neg;
    logic [N-1:0]    res;
    logic            res_ovf;
    logic            res_dbz;

    // Negating -2^(N-1) wraps to 2^(N-1), which is exact when read as unsigned.
    always_comb begin
        abs_a    = a[N-1] ? (~a + 1'b1) : a;
        abs_b    = b[N-1] ? (~b + 1'b1) : b;
        dividend = QW'(abs_a) << (QW - N);
    end

    divider_restoring_core #(
        .W  (N),
        .QW (QW)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     ((state_q == StIdle) && start),
        .step     (state_q == StCalc),
        .dividend (dividend),
        .divisor  (abs_b),
        .quotient (quotient),
        .last     (core_last)
    );

    always_comb begin
`ifdef DIV_ROUNDING_EN
        mag = MagW'(quotient[QW-1:1]) + MagW'(quotient[0]);
`else
        mag = MagW'(quotient);
`endif
        neg     = sign_q && (mag != '0);
        res     = mag[N-1:0];
        res_ovf = 1'b0;
        res_dbz = 1'b0;
        if (b_zero_q) begin
            res     = a_sign_q ? SatNegN : SatPosN;
            res_ovf = 1'b1;
            res_dbz = 1'b1;
        end else if (neg) begin
            if (mag > MagW'(SatNegN)) begin
                res     = SatNegN;
                res_ovf = 1'b1;
            end else begin
                res = -mag[N-1:0];
            end
        end else if (mag > MagW'(SatPosN)) begin
            res     = SatPosN;
            res_ovf = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            sign_q      <= 1'b0;
            a_sign_q    <= 1'b0;
            b_zero_q    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            q_result    <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        sign_q   <= a[N-1] ^ b[N-1];
                        a_sign_q <= a[N-1];
                        b_zero_q <= (b == '0);
                        busy     <= 1'b1;
                        state_q  <= (b == '0) ? StFinish : StCalc;
                    end
                end
                StCalc: begin
                    if (core_last) state_q <= StFinish;
                end
                StFinish: begin
                    q_result    <= res;
                    overflow    <= res_ovf;
                    div_by_zero <= res_dbz;
                    done        <= 1'b1;
                    state_q     <= StDone;
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_fixed_point_16_bit.sv
// Scoreboard bench for divider_fixed_point_16_bit: directed vectors, decoupled done monitor.
module tb_divider_fixed_point_16_bit;
    import divider_fixed_point_16_bit_pkg::*;

`ifdef DIV_ROUNDING_EN
    localparam int Lat = 31;
    localparam logic [15:0] TwoThirds = 16'h0AAB;
`else
    localparam int Lat = 30;
    localparam logic [15:0] TwoThirds = 16'h0AAA;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q_result;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        div_by_zero;

    always #5 clk = ~clk;

    divider_fixed_point_16_bit #(
        .Q (12),
        .N (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .q_result    (q_result),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        string       name;
        logic [15:0] q;
        logic        ovf;
        logic        dbz;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(posedge clk) begin
        #1;
        if (done) begin
            chk("done_one_cycle", 32'(prev_done), 32'd0);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending op", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_q"}, 32'(q_result), 32'(mon_e.q));
                chk({mon_e.name, "_ovf"}, 32'(overflow), 32'(mon_e.ovf));
                chk({mon_e.name, "_dbz"}, 32'(div_by_zero), 32'(mon_e.dbz));
                chk({mon_e.name, "_latency"}, 32'(cyc - mon_e.t0 + 1), 32'(mon_e.lat));
            end
        end
        prev_done = done;
    end

    task automatic issue(input string name, input logic [15:0] av, input logic [15:0] bv,
                         input logic [15:0] eq, input logic eo, input logic ed, input int el);
        exp_t e;
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        e.name = name;
        e.q    = eq;
        e.ovf  = eo;
        e.dbz  = ed;
        e.lat  = el;
        e.t0   = cyc;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d pending ops after 100 cycles, expected 0",
                     name, sb.size());
            sb.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic run(input string name, input logic [15:0] av, input logic [15:0] bv,
                       input logic [15:0] eq, input logic eo, input logic ed, input int el);
        issue(name, av, bv, eq, eo, ed, el);
        drain(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_q", 32'(q_result), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_flags", 32'({overflow, div_by_zero}), 32'd0);
        rst = 1'b0;

        issue("three_by_two", 16'h3000, 16'h2000, 16'h1800, 1'b0, 1'b0, Lat);
        chk("busy_in_calc", 32'(busy), 32'd1);
        drain("three_by_two");
        run("neg_by_pos", 16'hE800, 16'h0800, 16'hD000, 1'b0, 1'b0, Lat);
        run("pos_ovf", 16'h7000, 16'h0400, SatPos, 1'b1, 1'b0, Lat);
        run("neg_ovf", 16'h9000, 16'h0400, SatNeg, 1'b1, 1'b0, Lat);
        run("min_by_one", 16'h8000, 16'h1000, 16'h8000, 1'b0, 1'b0, Lat);
        run("min_by_neg_one", 16'h8000, 16'hF000, SatPos, 1'b1, 1'b0, Lat);
        run("zero_by_neg", 16'h0000, 16'hF000, 16'h0000, 1'b0, 1'b0, Lat);
        run("two_thirds", 16'h2000, 16'h3000, TwoThirds, 1'b0, 1'b0, Lat);
        run("one_third", 16'h1000, 16'h3000, 16'h0555, 1'b0, 1'b0, Lat);
        run("neg_one_third", 16'hF000, 16'h3000, 16'hFAAB, 1'b0, 1'b0, Lat);
        run("zero_by_zero", 16'h0000, 16'h0000, SatPos, 1'b1, 1'b1, 2);

        // A start with new operands while busy must be ignored.
        issue("start_while_busy", 16'h3000, 16'h2000, 16'h1800, 1'b0, 1'b0, Lat);
        repeat (9) @(posedge clk);
        @(negedge clk);
        a = 16'h1000;
        b = 16'h3000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain("start_while_busy");

        run("pos_by_zero", 16'h1000, 16'h0000, SatPos, 1'b1, 1'b1, 2);
        run("neg_by_zero", 16'hF000, 16'h0000, SatNeg, 1'b1, 1'b1, 2);

        // Reset mid-CALC: outputs cleared, and the monitor flags any done that follows.
        @(negedge clk);
        a = 16'h3000;
        b = 16'h2000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_q", 32'(q_result), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_flags", 32'({overflow, div_by_zero}), 32'd0);
        repeat (40) @(posedge clk);

        run("after_abort", 16'hE800, 16'h0800, 16'hD000, 1'b0, 1'b0, Lat);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/divider_fixed_point_16_bit.md
DIVIDER_FIXED_POINT_16_BIT -- requirements
Module: divider_fixed_point_16_bit

Interface
REQ-001 SHALL have parameter Q, default 12, fraction bits of the Q(N-Q).Q operands and result.
REQ-002 SHALL have parameter N, default 16, operand and result width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1, request a division; sampled only in IDLE.
REQ-006 SHALL have ports a and b, input, N each: a is the dividend, b the divisor, both two's-complement fixed point.
REQ-007 SHALL have port q_result, output, N, the registered two's-complement quotient a/b.
REQ-008 SHALL have ports busy, done, overflow and div_by_zero, output, 1 each.
- busy: high in any state other than IDLE.
- done: one-cycle completion pulse.
- overflow: result saturated.
- div_by_zero: b was 0.

Function
REQ-009 SHALL use a 4-state FSM: IDLE, CALC, FINISH, DONE.
REQ-010 SHALL, in IDLE with start=1, register a, b, the result sign a[N-1]^b[N-1] and the N-bit magnitudes |a| and |b|; |-2^(N-1)| = 2^(N-1) SHALL be exact.
REQ-011 SHALL go from IDLE to CALC when b!=0, and directly to FINISH when b==0.
REQ-012 SHALL, in CALC, perform restoring division of (|a| << Q) by |b|, one quotient bit per cycle, MSB first, for N+Q cycles (28 at defaults); N+Q-bit quotient, N+1-bit partial remainder.
REQ-013 SHALL, in FINISH, register q_result, overflow and div_by_zero, then go to DONE.
REQ-014 SHALL, in DONE, assert done for exactly one cycle, then return to IDLE.
REQ-015 SHALL set the latency from the start edge to the done-high cycle as follows:
- N+Q+2 cycles (30 at defaults) for a normal division;
- 2 cycles for divide-by-zero.
REQ-016 SHALL ignore start while busy=1; the operands are not re-sampled.
REQ-017 SHALL treat the result sign as positive when the quotient magnitude is 0 (no 0x8000 "negative zero" produced from 0).
REQ-018 SHALL saturate on overflow and set overflow=1:
- a positive result whose magnitude exceeds 2^(N-1)-1 gives 0x7FFF;
- a negative result whose magnitude exceeds 2^(N-1) gives 0x8000;
- a negative magnitude of exactly 2^(N-1) gives 0x8000 with overflow=0.
REQ-019 SHALL, on b==0, output 0x7FFF when a[N-1]=0 and 0x8000 when a[N-1]=1, with div_by_zero=1 and overflow=1.
REQ-020 SHALL, without rounding, truncate the magnitude toward zero and negate it for negative results (symmetric truncation).
REQ-021 SHALL hold q_result, overflow and div_by_zero from FINISH until the next FINISH or reset.

Reset
REQ-022 SHALL, with rst=1 at a clock edge, force the state to IDLE and clear q_result, overflow, div_by_zero, done and busy to 0; rst takes priority over start.
REQ-023 SHALL, on reset mid-CALC, abort the operation without asserting done.

Configuration
REQ-024 SHALL, when DIV_ROUNDING_EN is defined:
- run N+Q+1 CALC cycles, the extra cycle producing a guard bit;
- round the magnitude half-up before the sign is applied and before the saturation check;
- give a normal-division latency of N+Q+3 cycles.
REQ-025 SHALL, when DIV_ROUNDING_EN is undefined, build no guard-bit logic and behave per REQ-020.

Structure
REQ-026 SHALL place in a shared package:
- the FSM state encoding (2-bit localparams);
- default Q and N;
- the saturation constants 0x7FFF and 0x8000 (derived from N).
REQ-027 SHALL isolate the iterative remainder/quotient datapath in one sub-module, divider_restoring_core, with no knowledge of sign or saturation.

Verification
REQ-028 SHALL cover a=0x3000 (3.0), b=0x2000 (2.0), start pulse: q_result=0x1800, overflow=0, done high 30 cycles after start.
REQ-029 SHALL cover a=0xE800 (-1.5), b=0x0800 (0.5): q_result=0xD000 (-3.0), overflow=0.
REQ-030 SHALL cover a=0x7000 (7.0), b=0x0400 (0.25): overflow=1, q_result=0x7FFF; a=0x9000, b=0x0400: q_result=0x8000, overflow=1.
REQ-031 SHALL cover a=0x1000, b=0x0000: done 2 cycles after start, q_result=0x7FFF, div_by_zero=1, overflow=1.
REQ-032 SHALL cover a=0x2000, b=0x3000: q_result=0x0AAA without DIV_ROUNDING_EN and 0x0AAB with it; a=0x1000, b=0x3000: 0x0555 in both builds.
REQ-033 SHALL cover these disturbance cases:
- a start pulse 10 cycles into CALC with new operands is ignored, and the result matches the first operands;
- rst asserted mid-CALC: no done pulse, all outputs 0, and the next start operates normally.
